rgb_in_fifo: RTL and testbench
==============================

RGB_IN_FIFO -- requirements
Module: rgb_in_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter FRAME_PIXELS, default 16, meaning pixels per frame for Frame_Done; legal range is 1 to 2^20.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port CLEAR  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port In_Valid  input  1  upstream pixel present.
REQ-006 SHALL have port In_Ready  output  1  FIFO can accept a pixel.
REQ-007 SHALL have ports R_In, G_In, B_In  input  8 each  upstream pixel channels.
REQ-008 SHALL have port Out_Valid  output  1  head pixel available to the gray converter.
REQ-009 SHALL have port Out_Ready  input  1  converter consumes the head pixel.
REQ-010 SHALL have ports R_Out, G_Out, B_Out  output  8 each  head pixel channels.
REQ-011 SHALL have port Count  output  log2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port Frame_Done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 SHALL define a write as In_Valid=1 and In_Ready=1 on a rising edge; the write stores {R_In,G_In,B_In} at the write pointer.
REQ-014 SHALL define a read as Out_Valid=1 and Out_Ready=1 on a rising edge; the read advances the read pointer.
REQ-015 SHALL drive In_Ready = (Count != DEPTH) and Out_Valid = (Count != 0), both combinationally from registered state.
REQ-016 SHALL present the entry at the read pointer on R_Out/G_Out/B_Out whenever Out_Valid=1; these outputs hold their last value when Out_Valid=0.
REQ-017 SHALL assert Out_Valid for a pixel no earlier than the cycle after it is written; there is no combinational In-to-Out bypass.
REQ-018 SHALL update Count by +1 on a write only, -1 on a read only, and 0 on both or neither.
REQ-019 SHALL, when full, accept a read and no write in the same cycle; upstream re-presents the pixel, and In_Ready rises in the next cycle.
REQ-020 SHALL, when empty, ignore Out_Ready; a write in that cycle makes Out_Valid=1 in the next cycle.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH, and SHALL never overwrite or reorder entries.
REQ-022 SHALL require In_Valid and the R/G/B inputs to be held stable until accepted; the FIFO does not check this.
REQ-023 SHALL count reads in a pixel counter; on the read that brings the counter to FRAME_PIXELS, it SHALL pulse Frame_Done high in the next cycle for one cycle and reset the counter to 0.

Reset
REQ-024 SHALL, while CLEAR=1, asynchronously force the pointers, Count, and the pixel counter to 0, Frame_Done to 0, and R_Out/G_Out/B_Out to 0.
REQ-025 SHALL therefore give In_Ready=1 and Out_Valid=0 during reset and in the first cycle after release.
REQ-026 SHALL discard all stored pixels when CLEAR is asserted mid-transfer, including a pending read or write, and SHALL not reset storage contents.
REQ-027 SHALL perform its first write on the first rising edge after CLEAR deasserts.

Configuration
REQ-028 SHALL use macro RGB_IN_FRAME_CNT_EN: when defined, the pixel counter and Frame_Done behave per REQ-023.
REQ-029 SHALL, when RGB_IN_FRAME_CNT_EN is undefined, omit the pixel counter logic and tie Frame_Done to 0; all other behaviour is identical and the port list is unchanged.

Verification
REQ-030 SHALL cover reset release: in the first cycle, In_Ready=1, Out_Valid=0, Count=0, and R/G/B_Out=0.
REQ-031 SHALL cover fill without reads: write 4 pixels (DEPTH=4) with Out_Ready=0 -> Count=4, In_Ready=0, and a 5th pixel is held off.
REQ-032 SHALL cover drain order: write (10,20,30),(40,50,60), then Out_Ready=1 -> outputs (10,20,30) then (40,50,60), then Out_Valid=0 and Count=0.
REQ-033 SHALL cover full with read: at Count=4 with In_Valid=1 and Out_Ready=1 -> read only, Count=3; the next cycle writes and Count returns to 4.
REQ-034 SHALL cover wrap-around: stream 37 pixels with random Out_Ready -> output sequence equals input sequence and Count never exceeds 4.
REQ-035 SHALL cover frame pulse (macro defined, FRAME_PIXELS=16): 32 reads -> exactly 2 one-cycle Frame_Done pulses, each after reads 16 and 32; with the macro undefined, Frame_Done stays 0.

Source files
------------

// File: rtl/rgb_in_fifo.sv
// rgb_in_fifo: small RGB pixel FIFO between the pixel source and the gray
// converter. Valid/ready on both sides, registered head-of-queue outputs.
// Optional end-of-frame pulse enabled by defining RGB_IN_FRAME_CNT_EN.
module rgb_in_fifo #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FRAME_PIXELS = 16
) (
    input  logic                     CLK,
    input  logic                     CLEAR,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [7:0]               R_In,
    input  logic [7:0]               G_In,
    input  logic [7:0]               B_In,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [7:0]               R_Out,
    output logic [7:0]               G_Out,
    output logic [7:0]               B_Out,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Frame_Done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [23:0]   head_q, head_d;
    logic [23:0]   in_pix;
    logic          wr_en;
    logic          rd_en;

    assign in_pix    = {R_In, G_In, B_In};
    assign In_Ready  = (count_q != CW'(DEPTH));
    assign Out_Valid = (count_q != '0);
    assign wr_en     = In_Valid & In_Ready;
    assign rd_en     = Out_Ready & Out_Valid;

    assign Count = count_q;
    assign R_Out = head_q[23:16];
    assign G_Out = head_q[15:8];
    assign B_Out = head_q[7:0];

    // Next pointers, occupancy and the pixel that will sit at the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Head only changes when something is queued; otherwise it holds.
        // The new head is the incoming pixel exactly when it lands in the
        // slot the read pointer is about to point at (queue had one entry
        // or was empty).
        if (count_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = in_pix;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Pointer, occupancy and head registers with asynchronous clear.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Pixel storage; deliberately not cleared, pointers define validity.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_pix;
        end
    end

`ifdef RGB_IN_FRAME_CNT_EN
    localparam int unsigned PW = $clog2(FRAME_PIXELS + 1);
    localparam logic [PW-1:0] FRAME_LAST = PW'(FRAME_PIXELS);

    logic [PW-1:0] pix_cnt_q;
    logic          frame_q;

    // Count consumed pixels; pulse one cycle after the last pixel of a frame.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            pix_cnt_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (rd_en) begin
                if (pix_cnt_q + PW'(1) == FRAME_LAST) begin
                    pix_cnt_q <= '0;
                    frame_q   <= 1'b1;
                end else begin
                    pix_cnt_q <= pix_cnt_q + PW'(1);
                end
            end
        end
    end

    assign Frame_Done = frame_q;
`else
    // Frame counting disabled: pulse tied low; FRAME_PIXELS has no effect.
    assign Frame_Done = 1'b0 & (FRAME_PIXELS != 0);
`endif

endmodule

// File: tb/tb_rgb_in_fifo.sv
// Self-checking bench for rgb_in_fifo: vector table plus scoreboard model.
// Honours RGB_IN_FRAME_CNT_EN for the expected Frame_Done behaviour.
module tb_rgb_in_fifo;

    localparam int DEPTH = 4;
    localparam int FP    = 16;

    logic       clk;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] r_in, g_in, b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r_out, g_out, b_out;
    logic [2:0] count;
    logic       frame_done;

    rgb_in_fifo #(.DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
        .CLK        (clk),
        .CLEAR      (clear),
        .In_Valid   (in_valid),
        .In_Ready   (in_ready),
        .R_In       (r_in),
        .G_In       (g_in),
        .B_In       (b_in),
        .Out_Valid  (out_valid),
        .Out_Ready  (out_ready),
        .R_Out      (r_out),
        .G_Out      (g_out),
        .B_Out      (b_out),
        .Count      (count),
        .Frame_Done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         iv;
        logic [7:0] r, g, b;
        bit         ordy;
        int         cnt;
        bit         ir;
        bit         ov;
        logic [7:0] er, eg, eb;
    } vec_t;

    vec_t        vq[$];
    logic [23:0] sb[$];
    int          total = 0;
    int          bad = 0;
    int          m_count = 0;
    int          m_pc = 0;
    bit          m_fd = 0;
    int          m_reads = 0;
    int          dut_pulses = 0;
    bit          last_wr = 0;
    logic [23:0] cur;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit iv, int r, int g, int b, bit ordy, int cnt, bit ir,
                                bit ov, int er, int eg, int eb);
        vec_t v;
        v.iv = iv; v.r = 8'(r); v.g = 8'(g); v.b = 8'(b); v.ordy = ordy;
        v.cnt = cnt; v.ir = ir; v.ov = ov; v.er = 8'(er); v.eg = 8'(eg); v.eb = 8'(eb);
        return v;
    endfunction

    // Drive inputs just after a rising edge, then move to the sampling edge.
    task automatic cycle_begin(input bit iv, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input bit ordy);
        in_valid = iv; r_in = r; g_in = g; b_in = b; out_ready = ordy;
        @(negedge clk);
    endtask

    // At the sampling edge: compare against the model, update it, advance.
    task automatic cycle_end();
        bit wr, rd;
        logic [23:0] e;
        chk("in_ready", in_ready, m_count != DEPTH);
        chk("out_valid", out_valid, m_count != 0);
        chk("count", count, m_count);
        chk("frame_done", frame_done, m_fd);
        if (frame_done) dut_pulses++;
        wr = in_valid && (m_count != DEPTH);
        rd = out_ready && (m_count != 0);
        if (rd && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_r", r_out, e[23:16]);
            chk("sb_g", g_out, e[15:8]);
            chk("sb_b", b_out, e[7:0]);
            m_reads++;
        end
        if (wr) sb.push_back({r_in, g_in, b_in});
        m_count = m_count + int'(wr) - int'(rd);
        m_fd = 0;
`ifdef RGB_IN_FRAME_CNT_EN
        if (rd) begin
            m_pc++;
            if (m_pc == FP) begin
                m_fd = 1;
                m_pc = 0;
            end
        end
`endif
        last_wr = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_pc = 0;
        m_fd = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrs;
        int r0;
        bit done;
        logic [7:0] p;
        int exp_pulses;

        // Drain order, fill/hold-off, full-with-read, read+write cases.
        vq.push_back(mk(1, 10, 20, 30, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 40, 50, 60, 0, 1, 1, 1, 10, 20, 30));
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 10, 20, 30));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 40, 50, 60));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 40, 50, 60));
        vq.push_back(mk(1, 1, 2, 3, 0, 0, 1, 0, 40, 50, 60));
        vq.push_back(mk(1, 4, 5, 6, 0, 1, 1, 1, 1, 2, 3));
        vq.push_back(mk(1, 7, 8, 9, 0, 2, 1, 1, 1, 2, 3));
        vq.push_back(mk(1, 11, 12, 13, 0, 3, 1, 1, 1, 2, 3));
        vq.push_back(mk(1, 14, 15, 16, 0, 4, 0, 1, 1, 2, 3));
        vq.push_back(mk(1, 14, 15, 16, 0, 4, 0, 1, 1, 2, 3));
        vq.push_back(mk(1, 14, 15, 16, 1, 4, 0, 1, 1, 2, 3));
        vq.push_back(mk(1, 14, 15, 16, 0, 3, 1, 1, 4, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 4, 0, 1, 4, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 1, 4, 0, 1, 4, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 7, 8, 9));
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 11, 12, 13));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 14, 15, 16));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 14, 15, 16));
        vq.push_back(mk(1, 21, 22, 23, 1, 0, 1, 0, 14, 15, 16));
        vq.push_back(mk(1, 24, 25, 26, 1, 1, 1, 1, 21, 22, 23));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 24, 25, 26));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 24, 25, 26));

        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_rgb", {r_out, g_out, b_out}, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk);
        clear = 1'b0;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_count", count, 0);
        chk("rel_rgb", {r_out, g_out, b_out}, 0);
        cycle_end();

        foreach (vq[i]) begin
            cycle_begin(vq[i].iv, vq[i].r, vq[i].g, vq[i].b, vq[i].ordy);
            chk("tbl_count", count, vq[i].cnt);
            chk("tbl_in_ready", in_ready, vq[i].ir);
            chk("tbl_out_valid", out_valid, vq[i].ov);
            chk("tbl_rgb", {r_out, g_out, b_out}, {vq[i].er, vq[i].eg, vq[i].eb});
            cycle_end();
        end

        // Clear mid-transfer with a pending read and write.
        for (int i = 0; i < 3; i++) begin
            cycle_begin(1, 8'hA0 + 8'(i), 8'hB0, 8'hC0, 0);
            cycle_end();
        end
        in_valid = 1'b1; out_ready = 1'b1;
        r_in = 8'h55; g_in = 8'h66; b_in = 8'h77;
        #2;
        clear = 1'b1;
        #1;
        chk("mid_count", count, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_rgb", {r_out, g_out, b_out}, 0);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        r_in = 8'd99; g_in = 8'd98; b_in = 8'd97;
        cycle_end();
        cycle_begin(0, 0, 0, 0, 0);
        chk("first_wr_count", count, 1);
        chk("first_wr_rgb", {r_out, g_out, b_out}, {8'd99, 8'd98, 8'd97});
        cycle_end();
        cycle_begin(0, 0, 0, 0, 1);
        cycle_end();

        // Wrap-around stream with random backpressure on both sides.
        wrs = 0;
        r0 = m_reads;
        done = 0;
        cur = 24'($urandom);
        for (int c = 0; c < 2000 && !done; c++) begin
            cycle_begin((wrs < 37) && ($urandom_range(0, 3) != 0),
                        cur[23:16], cur[15:8], cur[7:0], 1'($urandom_range(0, 1)));
            chk("wrap_count_le_depth", int'(count <= 3'(DEPTH)), 1);
            cycle_end();
            if (last_wr) begin
                wrs++;
                cur = 24'($urandom);
            end
            if (m_reads - r0 == 37) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wrap_timeout got=%0d exp=37", m_reads - r0);
        end

        // Frame pulse: 32 reads from a clean counter.
        clear = 1'b1;
        #2;
        clear = 1'b0;
        model_reset();
        dut_pulses = 0;
        r0 = m_reads;
        p = 8'd0;
        for (int c = 0; c < 200 && (m_reads - r0) < 32; c++) begin
            cycle_begin(1, p, p ^ 8'h5a, ~p, 1);
            cycle_end();
            if (last_wr) p++;
        end
        in_valid = 1'b0;
        repeat (3) begin
            cycle_begin(0, 0, 0, 0, 0);
            cycle_end();
        end
`ifdef RGB_IN_FRAME_CNT_EN
        exp_pulses = 2;
`else
        exp_pulses = 0;
`endif
        chk("frame_reads", m_reads - r0, 32);
        chk("frame_pulses", dut_pulses, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
